// File: rtl/plot_pkg.sv
// Shared types and constants for the object plotter: screen limits, colours,
// object codes, FSM state and the captured request record.
package plot_pkg;

    localparam logic [7:0] MAX_X = 8'd159;
    localparam logic [6:0] MAX_Y = 7'd119;

    localparam logic [2:0] BG_COLOUR     = 3'b000;
    localparam logic [2:0] BALL_COLOUR   = 3'b111;
    localparam logic [2:0] PADDLE_COLOUR = 3'b010;
    localparam logic [2:0] BLOCK_COLOUR  = 3'b100;

    localparam logic [1:0] OBJ_BALL   = 2'b00;
    localparam logic [1:0] OBJ_PADDLE = 2'b01;
    localparam logic [1:0] OBJ_BLOCK  = 2'b10;
    localparam logic [1:0] OBJ_NONE   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } plot_state_t;

    typedef struct packed {
        logic [1:0] obj;
        logic [7:0] new_x;
        logic [6:0] new_y;
        logic [7:0] old_x;
        logic [6:0] old_y;
        logic [7:0] size_x;
        logic [6:0] size_y;
    } plot_job_t;

    function automatic logic [2:0] obj_colour(input logic [1:0] obj);
        case (obj)
            OBJ_BALL:   obj_colour = BALL_COLOUR;
            OBJ_PADDLE: obj_colour = PADDLE_COLOUR;
            OBJ_BLOCK:  obj_colour = BLOCK_COLOUR;
            default:    obj_colour = BG_COLOUR;
        endcase
    endfunction

endpackage

// File: rtl/rect_scanner.sv
// Row-major raster walker over a rectangle. x/y/valid/last are registered and
// describe the pixel currently presented; valid drops whenever no pixel is issued.
module rect_scanner
    import plot_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       step,
    input  logic [7:0] base_x,
    input  logic [6:0] base_y,
    input  logic [7:0] width,
    input  logic [6:0] height,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       valid,
    output logic       last
);

    logic [7:0] col_q, col_d, bx_q, bx_d, w_q, w_d;
    logic [6:0] row_q, row_d, by_q, by_d, h_q, h_d;
    logic [7:0] x_d;
    logic [6:0] y_d;
    logic       valid_d, last_d;
    logic [8:0] sum_x;
    logic [7:0] sum_y;

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        bx_d    = bx_q;
        by_d    = by_q;
        w_d     = w_q;
        h_d     = h_q;
        x_d     = x;
        y_d     = y;
        valid_d = 1'b0;
        last_d  = 1'b0;
        sum_x   = '0;
        sum_y   = '0;
        if (start) begin
            bx_d  = base_x;
            by_d  = base_y;
            w_d   = width;
            h_d   = height;
            col_d = '0;
            row_d = '0;
        end else if (step) begin
            if (col_q == w_q - 8'd1) begin
                col_d = '0;
                row_d = row_q + 7'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
        end
        if (start || step) begin
            // Sums are one bit wider than the screen coordinate so nothing wraps back on screen.
            sum_x   = {1'b0, bx_d} + {1'b0, col_d};
            sum_y   = {1'b0, by_d} + {1'b0, row_d};
            x_d     = sum_x[7:0];
            y_d     = sum_y[6:0];
            valid_d = (sum_x <= {1'b0, MAX_X}) && (sum_y <= {1'b0, MAX_Y});
            last_d  = (col_d == w_d - 8'd1) && (row_d == h_d - 7'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            bx_q  <= '0;
            by_q  <= '0;
            w_q   <= '0;
            h_q   <= '0;
            x     <= '0;
            y     <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            bx_q  <= bx_d;
            by_q  <= by_d;
            w_q   <= w_d;
            h_q   <= h_d;
            x     <= x_d;
            y     <= y_d;
            valid <= valid_d;
            last  <= last_d;
        end
    end

endmodule

// File: rtl/object_plotter.sv
// Erases an object's old rectangle and draws its new one, one pixel per clock,
// with a single overwrite-on-arrival pending slot for requests made while busy.
module object_plotter
    import plot_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        startPlot,
    input  logic [1:0]  object,
    input  logic [7:0]  newX,
    input  logic [6:0]  newY,
    input  logic [7:0]  oldX,
    input  logic [6:0]  oldY,
    input  logic [7:0]  sizeX,
    input  logic [6:0]  sizeY,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done,
    output plot_state_t dbg_state
);

    plot_state_t state, state_d;
    plot_job_t   job_q, job_d, pend_job, pend_job_d, in_job, launch_job;
    logic        pend_valid, pend_valid_d;
    logic        req, launch_en, launch_empty, launch_same;
    logic [2:0]  colour_d;
    logic        busy_d, done_d;
    logic        sc_start, sc_step, sc_valid, sc_last;
    logic [7:0]  sc_bx, sc_x;
    logic [6:0]  sc_by, sc_y;

    assign req    = startPlot && (object != OBJ_NONE);
    assign in_job = '{obj: object, new_x: newX, new_y: newY, old_x: oldX,
                      old_y: oldY, size_x: sizeX, size_y: sizeY};

    // A strobe seen in the DONE cycle supersedes whatever is pending.
    always_comb begin
        launch_en    = ((state == ST_IDLE) && req) ||
                       ((state == ST_DONE) && (req || pend_valid));
        launch_job   = ((state == ST_DONE) && !req) ? pend_job : in_job;
        launch_empty = (launch_job.size_x == 8'd0) || (launch_job.size_y == 7'd0);
        launch_same  = (launch_job.old_x == launch_job.new_x) &&
                       (launch_job.old_y == launch_job.new_y);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            job_q      <= '0;
            pend_valid <= 1'b0;
            pend_job   <= '0;
            colour     <= BG_COLOUR;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            job_q      <= job_d;
            pend_valid <= pend_valid_d;
            pend_job   <= pend_job_d;
            colour     <= colour_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (launch_en) begin
                    if (launch_empty)     state_d = ST_DONE;
                    else if (launch_same) state_d = ST_DRAW;
                    else                  state_d = ST_ERASE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERASE: if (sc_last) state_d = ST_DRAW;
            ST_DRAW:  if (sc_last) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        job_d        = job_q;
        pend_valid_d = pend_valid;
        pend_job_d   = pend_job;
        colour_d     = colour;
        sc_start     = 1'b0;
        sc_step      = 1'b0;
        sc_bx        = job_q.new_x;
        sc_by        = job_q.new_y;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (launch_en) begin
                    job_d        = launch_job;
                    pend_valid_d = 1'b0;
                    if (!launch_empty) begin
                        sc_start = 1'b1;
                        sc_bx    = launch_same ? launch_job.new_x : launch_job.old_x;
                        sc_by    = launch_same ? launch_job.new_y : launch_job.old_y;
                        colour_d = launch_same ? obj_colour(launch_job.obj) : BG_COLOUR;
                    end
                end
            end
            ST_ERASE, ST_DRAW: begin
                if (req) begin
                    pend_valid_d = 1'b1;
                    pend_job_d   = in_job;
                end
                if (!sc_last) begin
                    sc_step = 1'b1;
                end else if (state == ST_ERASE) begin
                    sc_start = 1'b1;
                    colour_d = obj_colour(job_q.obj);
                end
            end
            default: ;
        endcase
        busy_d = (state_d == ST_ERASE) || (state_d == ST_DRAW);
        done_d = (state_d == ST_DONE);
    end

    rect_scanner u_scanner (
        .clk    (clk),
        .rst    (reset),
        .start  (sc_start),
        .step   (sc_step),
        .base_x (sc_bx),
        .base_y (sc_by),
        .width  (job_d.size_x),
        .height (job_d.size_y),
        .x      (sc_x),
        .y      (sc_y),
        .valid  (sc_valid),
        .last   (sc_last)
    );

    assign x         = sc_x;
    assign y         = sc_y;
    assign plot      = sc_valid;
    assign dbg_state = state;

endmodule

// File: tb/tb_object_plotter.sv
// Directed bench for object_plotter: erase/draw scans, clipping, pending
// overwrite, ignored/empty requests and asynchronous reset mid-job.
module tb_object_plotter;
    import plot_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        startPlot;
    logic [1:0]  object;
    logic [7:0]  newX, oldX, sizeX;
    logic [6:0]  newY, oldY, sizeY;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot, busy, done;
    plot_state_t dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    object_plotter dut (
        .clk       (clk),
        .reset     (reset),
        .startPlot (startPlot),
        .object    (object),
        .newX      (newX),
        .newY      (newY),
        .oldX      (oldX),
        .oldY      (oldY),
        .sizeX     (sizeX),
        .sizeY     (sizeY),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] obj, input int nx, input int ny,
                           input int ox, input int oy, input int sx, input int sy);
        object    = obj;
        newX      = 8'(nx);
        newY      = 7'(ny);
        oldX      = 8'(ox);
        oldY      = 7'(oy);
        sizeX     = 8'(sx);
        sizeY     = 7'(sy);
        startPlot = 1'b1;
    endtask

    // Called at a falling edge; returns at the falling edge of the first cycle after accept.
    task automatic pulse_req(input logic [1:0] obj, input int nx, input int ny,
                             input int ox, input int oy, input int sx, input int sy);
        set_req(obj, nx, ny, ox, oy, sx, sy);
        @(negedge clk);
        startPlot = 1'b0;
    endtask

    task automatic apply_req(input int sel);
        case (sel)
            0:       set_req(OBJ_PADDLE, 60, 50, 61, 50, 20, 1);
            default: set_req(OBJ_BLOCK, 7, 8, 5, 6, 3, 2);
        endcase
    endtask

    task automatic expect_rect(input string tag, input int bx, input int by, input int w,
                               input int h, input logic [2:0] col, input int req_at,
                               input int req_sel);
        int  i;
        logic exp_plot;
        i = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                exp_plot = ((bx + c) <= 159) && ((by + r) <= 119);
                check($sformatf("%s_plot[%0d]", tag, i), 32'(plot), 32'(exp_plot));
                check($sformatf("%s_busy[%0d]", tag, i), 32'(busy), 32'd1);
                if (exp_plot) begin
                    check($sformatf("%s_x[%0d]", tag, i), 32'(x), 32'(bx + c));
                    check($sformatf("%s_y[%0d]", tag, i), 32'(y), 32'(by + r));
                    check($sformatf("%s_col[%0d]", tag, i), 32'(colour), 32'(col));
                end
                if (i == req_at) apply_req(req_sel);
                @(negedge clk);
                startPlot = 1'b0;
                i++;
            end
        end
    endtask

    task automatic expect_done(input string tag);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_plot"}, 32'(plot), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_DONE));
        @(negedge clk);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_plot"}, 32'(plot), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        reset     = 1'b1;
        startPlot = 1'b0;
        object    = OBJ_NONE;
        newX = '0; newY = '0; oldX = '0; oldY = '0; sizeX = '0; sizeY = '0;
        repeat (2) @(negedge clk);
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_colour", 32'(colour), 32'd0);
        expect_idle("rst");
        reset = 1'b0;
        @(negedge clk);

        // Ball: erase 51..54/4..7 black, draw 52..55/5..8 white, done on cycle 33.
        pulse_req(OBJ_BALL, 52, 5, 51, 4, 4, 4);
        expect_rect("ball_erase", 51, 4, 4, 4, BG_COLOUR, -1, 0);
        expect_rect("ball_draw", 52, 5, 4, 4, BALL_COLOUR, -1, 0);
        expect_done("ball");
        expect_idle("ball_after");
        @(negedge clk);

        // Paddle: one-row rectangle.
        pulse_req(OBJ_PADDLE, 99, 117, 100, 117, 20, 1);
        expect_rect("pad_erase", 100, 117, 20, 1, BG_COLOUR, -1, 0);
        expect_rect("pad_draw", 99, 117, 20, 1, PADDLE_COLOUR, -1, 0);
        expect_done("pad");
        expect_idle("pad_after");
        @(negedge clk);

        // Clipping at the bottom-right corner, no erase since old == new.
        pulse_req(OBJ_BALL, 158, 118, 158, 118, 4, 4);
        expect_rect("clip_draw", 158, 118, 4, 4, BALL_COLOUR, -1, 0);
        expect_done("clip");
        expect_idle("clip_after");
        @(negedge clk);

        // Pending: paddle strobe at cycle 5, replaced by a block strobe during draw.
        pulse_req(OBJ_BALL, 11, 11, 10, 10, 4, 4);
        expect_rect("pend_erase", 10, 10, 4, 4, BG_COLOUR, 4, 0);
        expect_rect("pend_draw", 11, 11, 4, 4, BALL_COLOUR, 3, 1);
        expect_done("pend_ball");
        expect_rect("blk_erase", 5, 6, 3, 2, BG_COLOUR, -1, 0);
        expect_rect("blk_draw", 7, 8, 3, 2, BLOCK_COLOUR, -1, 0);
        expect_done("blk");
        expect_idle("blk_after");
        @(negedge clk);

        // Object code 11 is ignored.
        pulse_req(OBJ_NONE, 20, 20, 10, 10, 4, 4);
        expect_idle("none_a");
        @(negedge clk);
        expect_idle("none_b");

        // Empty job: done the cycle after accept, never busy.
        pulse_req(OBJ_BALL, 1, 1, 2, 2, 0, 4);
        expect_done("empty");
        expect_idle("empty_after");
        @(negedge clk);

        // Reset mid-draw with a paddle request pending.
        pulse_req(OBJ_BALL, 30, 30, 30, 30, 4, 4);
        expect_rect("rst_draw", 30, 30, 4, 1, BALL_COLOUR, 1, 0);
        check("pre_rst_plot", 32'(plot), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_x", 32'(x), 32'd0);
        expect_idle("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            expect_idle($sformatf("post_rst%0d", k));
        end
        pulse_req(OBJ_BALL, 0, 0, 0, 0, 2, 1);
        expect_rect("post_draw", 0, 0, 2, 1, BALL_COLOUR, -1, 0);
        expect_done("post");
        expect_idle("post_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
